mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, width of the word address.
REQ-002 SHALL have parameter DATA_W, default 16, width of the memory word.
REQ-003 SHALL have parameter MEM_DEPTH, default 10, number of implemented words; valid addresses are 0..MEM_DEPTH-1.
REQ-004 SHALL have the port list below; one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1 each  transfer request, port 0 / port 1.
- we0 / we1  in  1 each  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W each  word address.
- wdata0 / wdata1  in  DATA_W each  write data.
- ack0 / ack1  out  1 each  one-cycle completion pulse.
- rdata  out  DATA_W  read data; valid while ack0 or ack1 is high.
- err  out  1  address-range error; qualified by ack0 or ack1.
- mem_read / mem_write  out  1 each  memory strobes (memory acts on their rising edge).
- mem_i  out  ADDR_W  memory address.
- mem_memin  out  DATA_W  memory write data.
- mem_memout  in  DATA_W  memory read data.

Function
REQ-005 SHALL implement FSM states IDLE, SETUP, STRB, CAPT, DONE.
REQ-006 IDLE: on any reqN high, pick a winner per REQ-012; latch its we, addr and wdata; go to SETUP. If no reqN is high, stay in IDLE.
REQ-007 IDLE: if the latched addr >= MEM_DEPTH, go directly to DONE with err=1; no strobe is issued.
REQ-008 SETUP: drive mem_i and mem_memin from the latches, both strobes 0.
REQ-009 STRB: assert exactly one strobe (mem_write if we, else mem_read) for exactly one cycle; mem_i and mem_memin stay stable.
REQ-010 CAPT: both strobes 0; on a read, register mem_memout into rdata at the end of the cycle. On a write, rdata is unchanged.
REQ-011 DONE: ackN=1 for the granted port only, for one cycle; err=0 on a valid access; then go to IDLE.
- Latency for a valid access: ack in the 4th cycle after the cycle in which IDLE samples req.
- Latency for an error access: ack in the 1st cycle after that sample.
REQ-012 Arbitration: fixed priority, port 0 over port 1, unless modified by REQ-017.
REQ-013 Handshake: the requester SHALL hold reqN, weN, addrN and wdataN until ackN, and SHALL drop reqN in the cycle after ackN.
- The arbiter ignores changes to these inputs once they are latched.
REQ-014 A request on the non-granted port remains pending and SHALL be granted in the next IDLE cycle in which it wins arbitration; no request is dropped.
REQ-015 mem_read and mem_write SHALL never be high together, and SHALL never be high outside STRB.

Reset
REQ-016 On reset:
- state goes to IDLE.
- ack0, ack1, err, mem_read and mem_write go to 0 at that edge.
- rdata, mem_i and mem_memin go to 0.
- the round-robin pointer selects port 0.
- any in-flight transaction is abandoned with no ack; asserting reset in STRB SHALL drop the strobe at that edge.

Configuration
REQ-017 With macro MEM_ARB_RR_EN defined, arbitration SHALL be round-robin:
- A 1-bit pointer names the preferred port.
- When both ports request, the pointer selects the winner.
- At each grant, the pointer moves to the other port.
- Without MEM_ARB_RR_EN, fixed priority per REQ-012 applies and no pointer flop exists.

Structure
REQ-018 Package mem_arb_pkg SHALL hold ADDR_W, DATA_W, MEM_DEPTH defaults and the FSM state typedef.
REQ-019 One sub-module, mem_arb_pick, SHALL hold the combinational winner selection, including the pointer logic under MEM_ARB_RR_EN. All other logic SHALL reside in mem_arbiter.

Verification
REQ-020 With the memory's power-up contents: req0=1, we0=0, addr0=1 -> ack0 4 cycles later with rdata=16'h72bb, err=0; exactly one mem_read pulse.
REQ-021 req1=1, we1=1, addr1=7, wdata1=16'h1234, then req0 read of addr 7 -> ack1, then ack0 with rdata=16'h1234; exactly one mem_write pulse; mem_read never high with mem_write.
REQ-022 req0 and req1 both held for two transactions:
- with MEM_ARB_RR_EN, acks in order port 0 then port 1;
- without it, port 0 wins whenever both request, and port 1 is served only once req0 is low.
REQ-023 req0 read with addr0=12'h00A -> ack0 with err=1 one cycle after the IDLE sample; no strobe; rdata unchanged.
REQ-024 reset asserted during STRB -> mem_read=0 after that edge, state IDLE, no ack; a subsequent read of addr 0 returns 16'h90aa.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: default sizes and fsm state type shared by the mem_arbiter files
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;
  localparam int MEM_DEPTH_DEF = 10;
  typedef enum logic [2:0] {IDLE, SETUP, STRB, CAPT, DONE} state_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: winner select, port 0 priority or round-robin pointer under MEM_ARB_RR_EN
module mem_arb_pick (
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic reset,
  input  logic take,
`endif
  input  logic req0,
  input  logic req1,
  output logic gnt_any,
  output logic gnt_sel
);
  assign gnt_any = req0 | req1;
`ifdef MEM_ARB_RR_EN
  logic ptr_q;
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else if (take && gnt_any) ptr_q <= ~gnt_sel;
  end
  assign gnt_sel = (req0 && req1) ? ptr_q : req1;
`else
  assign gnt_sel = req0 ? 1'b0 : req1;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter for a strobed memory, fixed priority or round-robin with MEM_ARB_RR_EN
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_i,
  output logic [DATA_W-1:0] mem_memin,
  input  logic [DATA_W-1:0] mem_memout
);
  state_t state_q;
  logic we_q, gnt_q, gnt_any, gnt_sel;
  logic [ADDR_W-1:0] addr_sel;
  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk(clk),
    .reset(reset),
    .take(state_q == IDLE),
`endif
    .req0(req0),
    .req1(req1),
    .gnt_any(gnt_any),
    .gnt_sel(gnt_sel)
  );
  assign addr_sel = gnt_sel ? addr1 : addr0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      gnt_q     <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rdata     <= '0;
      mem_i     <= '0;
      mem_memin <= '0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state_q)
        IDLE: if (gnt_any) begin
          gnt_q     <= gnt_sel;
          we_q      <= gnt_sel ? we1 : we0;
          mem_i     <= addr_sel;
          mem_memin <= gnt_sel ? wdata1 : wdata0;
          if (addr_sel >= ADDR_W'(MEM_DEPTH)) begin
            state_q <= DONE;
            err     <= 1'b1;
            ack0    <= ~gnt_sel;
            ack1    <= gnt_sel;
          end else state_q <= SETUP;
        end
        SETUP: begin
          state_q   <= STRB;
          mem_read  <= ~we_q;
          mem_write <= we_q;
        end
        STRB: state_q <= CAPT;
        CAPT: begin
          state_q <= DONE;
          ack0    <= ~gnt_q;
          ack1    <= gnt_q;
          if (!we_q) rdata <= mem_memout;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int DEPTH = 10;
  typedef struct packed {logic we; logic [11:0] addr; logic [15:0] wdata;} txn_t;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [11:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, err, mem_read, mem_write;
  logic [15:0] rdata, mem_memin;
  logic [15:0] mem_memout = '0;
  logic [11:0] mem_i;
  int checks = 0, errors = 0, cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, rd_hi = 0, wr_hi = 0;
  logic [15:0] phy_mem [DEPTH];
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] exp_rdata = '0;
  txn_t q0[$], q1[$];
`ifdef MEM_ARB_RR_EN
  bit ptr = 1'b0;
`endif
  mem_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_i(mem_i),
    .mem_memin(mem_memin), .mem_memout(mem_memout)
  );
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge mem_write) begin
    wr_cnt++;
    if (int'(mem_i) < DEPTH) phy_mem[mem_i] = mem_memin;
  end
  always @(posedge mem_read) begin
    rd_cnt++;
    mem_memout = (int'(mem_i) < DEPTH) ? phy_mem[mem_i] : 16'hdead;
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mem_read === 1'b1) rd_hi++;
    if (mem_write === 1'b1) wr_hi++;
    if (mem_read === 1'b1 && mem_write === 1'b1) check("strobe_excl", {mem_read, mem_write}, 0);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic txn_t mk(logic we, logic [11:0] addr, logic [15:0] wdata);
    txn_t t;
    t.we = we;
    t.addr = addr;
    t.wdata = wdata;
    return t;
  endfunction
  function automatic txn_t rnd_txn();
    return mk(1'($urandom_range(0, 1)), 12'($urandom_range(0, 11)), 16'($urandom));
  endfunction
  task automatic serve();
    int w, exp, last_w, rd0, wr0, rh0, wh0, n_rd, n_wr;
    logic r0, r1, bad, seen;
    txn_t t;
    last_w = -1;
    while (q0.size() + q1.size() > 0) begin
      r0 = q0.size() > 0 && last_w != 0;
      r1 = q1.size() > 0 && last_w != 1;
      last_w = -1;
      req0 = r0;
      req1 = r1;
      if (q0.size() > 0) {we0, addr0, wdata0} = q0[0];
      if (q1.size() > 0) {we1, addr1, wdata1} = q1[0];
      if (!r0 && !r1) begin
        step();
        continue;
      end
`ifdef MEM_ARB_RR_EN
      w = (r0 && r1) ? int'(ptr) : (r0 ? 0 : 1);
      ptr = (w == 0);
`else
      w = r0 ? 0 : 1;
`endif
      t = (w == 1) ? q1[0] : q0[0];
      bad = int'(t.addr) >= DEPTH;
      exp = cyc + (bad ? 1 : 4);
      rd0 = rd_cnt; wr0 = wr_cnt; rh0 = rd_hi; wh0 = wr_hi;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        step();
        seen = ack0 | ack1;
      end
      if (!bad && t.we) ref_mem[t.addr] = t.wdata;
      if (!bad && !t.we) exp_rdata = ref_mem[t.addr];
      n_rd = (!bad && !t.we) ? 1 : 0;
      n_wr = (!bad && t.we) ? 1 : 0;
      check("ack_cycle", cyc, exp);
      check("ack_port", {ack1, ack0}, (w == 1) ? 2 : 1);
      check("err", err, bad);
      check("rdata", rdata, exp_rdata);
      check("rd_pulses", rd_cnt - rd0, n_rd);
      check("wr_pulses", wr_cnt - wr0, n_wr);
      check("rd_width", rd_hi - rh0, n_rd);
      check("wr_width", wr_hi - wh0, n_wr);
      if (w == 1) void'(q1.pop_front());
      else void'(q0.pop_front());
      last_w = w;
      step();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
  endtask
  initial begin
    logic seen;
    logic [15:0] init_tab [DEPTH] = '{16'h90aa, 16'h72bb, 16'h0f0f, 16'h3c3c, 16'h5a5a,
                                      16'ha5a5, 16'hc3c3, 16'h0001, 16'hbeef, 16'hfeed};
    for (int i = 0; i < DEPTH; i++) begin
      phy_mem[i] = init_tab[i];
      ref_mem[i] = init_tab[i];
    end
    step();
    step();
    check("rst_ack", {ack1, ack0}, 0);
    check("rst_err", err, 0);
    check("rst_strobes", {mem_read, mem_write}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_i", mem_i, 0);
    check("rst_memin", mem_memin, 0);
    reset = 1'b0;
    step();
    repeat (2) q0.push_back(mk(1'b0, 12'd2, 16'h0));
    repeat (2) q1.push_back(mk(1'b0, 12'd3, 16'h0));
    serve();
    q0.push_back(mk(1'b0, 12'd1, 16'h0));
    serve();
    check("read_addr1", rdata, 16'h72bb);
    q1.push_back(mk(1'b1, 12'd7, 16'h1234));
    serve();
    q0.push_back(mk(1'b0, 12'd7, 16'h0));
    serve();
    check("readback_addr7", rdata, 16'h1234);
    q0.push_back(mk(1'b0, 12'h00a, 16'h0));
    serve();
    check("err_keeps_rdata", rdata, 16'h1234);
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'd3; wdata0 = '0;
    step();
    step();
    check("strb_read", mem_read, 1);
    reset = 1'b1;
    step();
    check("strb_rst_read", mem_read, 0);
    check("strb_rst_ack", {ack1, ack0}, 0);
    check("strb_rst_rdata", rdata, 0);
    reset = 1'b0;
    req0 = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      step();
      seen = seen | ack0 | ack1;
    end
    check("abandoned_no_ack", seen, 0);
    exp_rdata = '0;
`ifdef MEM_ARB_RR_EN
    ptr = 1'b0;
`endif
    q0.push_back(mk(1'b0, 12'd0, 16'h0));
    serve();
    check("read_addr0", rdata, 16'h90aa);
    for (int r = 0; r < 40; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 + n1 == 0) n0 = 1;
      repeat (n0) q0.push_back(rnd_txn());
      repeat (n1) q1.push_back(rnd_txn());
      serve();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
